// File: rtl/data_mem_responder.sv
// Data-memory slave for the MEM stage: word array with byte lanes, fixed multi-cycle latency,
// BUSY stall output, and a one-cycle ERROR for rejected requests.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY,
    output logic        ERROR,
    output logic [1:0]  dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ld_q, ld_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    logic          req, ld_bad, st_bad, illegal, commit;
    logic          c_ld;
    logic [2:0]    c_f3;
    logic [AW+1:0] c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_word;
    logic          unused_addr_bits;

    // Address bits above the array index wrap onto the same words.
    assign unused_addr_bits = ^ADDRESS[31:AW+2];

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] sz, input logic [1:0] a);
        store_merge = w;
        case (sz)
            2'b00: begin
                case (a)
                    2'd0:    store_merge[7:0]   = d[7:0];
                    2'd1:    store_merge[15:8]  = d[7:0];
                    2'd2:    store_merge[23:16] = d[7:0];
                    default: store_merge[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (a[1]) store_merge[31:16] = d[15:0];
                else      store_merge[15:0]  = d[15:0];
            end
            default: store_merge = d;
        endcase
    endfunction

    always_comb begin
        req    = READ[3] | WRITE[2];
        ld_bad = READ[3] && ((READ[2:0] inside {3'b011, 3'b110, 3'b111}) ||
                             (READ[1:0] == 2'b01 && ADDRESS[0]) ||
                             (READ[2:0] == 3'b010 && ADDRESS[1:0] != 2'b00));
        st_bad = WRITE[2] && ((WRITE[1:0] == 2'b11) ||
                              (WRITE[1:0] == 2'b01 && ADDRESS[0]) ||
                              (WRITE[1:0] == 2'b10 && ADDRESS[1:0] != 2'b00));
        illegal = (READ[3] && WRITE[2]) || ld_bad || st_bad;
    end

    // In IDLE the live inputs drive the commit path (needed when LATENCY is 1); later the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            c_ld    = READ[3];
            c_f3    = READ[3] ? READ[2:0] : {1'b0, WRITE[1:0]};
            c_addr  = ADDRESS[AW+1:0];
            c_wdata = WRITE_DATA;
        end else begin
            c_ld    = ld_q;
            c_f3    = f3_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
        c_idx  = c_addr[AW+1:2];
        c_word = mem_q[c_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        BUSY    = 1'b0;
        ERROR   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        ERROR = 1'b1;
                    end else begin
                        BUSY    = 1'b1;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                        ld_d    = c_ld;
                        f3_d    = c_f3;
                        cnt_d   = CNT_INIT;
                        if (LATENCY == 1) begin
                            state_d = DONE;
                            commit  = 1'b1;
                        end else begin
                            state_d = ACCESS;
                        end
                    end
                end
            end
            ACCESS: begin
                BUSY  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit && c_ld) begin
            rdata_d = load_ext(c_word, c_f3, c_addr[1:0]);
        end
        if (RESET) begin
            BUSY  = 1'b0;
            ERROR = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= 1'b0;
            f3_q    <= 3'b000;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; a store only lands on the edge that enters DONE.
    always_ff @(posedge CLK) begin
        if (commit && !c_ld && !RESET) begin
            mem_q[c_idx] <= store_merge(c_word, c_wdata, c_f3[1:0], c_addr[1:0]);
        end
    end

    assign READ_DATA   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a byte-addressed reference model.
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  read_s;
    logic [2:0]  write_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic [31:0] read_data_s;
    logic        busy_s;
    logic        err_s;
    logic [1:0]  dbg_state_s;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mbytes [4096];
    logic [31:0] exp_rd;

    data_mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .READ       (read_s),
        .WRITE      (write_s),
        .ADDRESS    (addr_s),
        .WRITE_DATA (wdata_s),
        .READ_DATA  (read_data_s),
        .BUSY       (busy_s),
        .ERROR      (err_s),
        .dbg_state_o(dbg_state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic is_ld, input logic [2:0] code);
        if (is_ld) begin
            case (code)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end else begin
            case (code[1:0])
                2'd0:    return 1;
                2'd1:    return 2;
                2'd2:    return 4;
                default: return 0;
            endcase
        end
    endfunction

    function automatic logic model_err(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a);
        int s;
        if (rd[3] && wr[2]) return 1'b1;
        if (!rd[3] && !wr[2]) return 1'b0;
        s = rd[3] ? op_size(1'b1, rd[2:0]) : op_size(1'b0, {1'b0, wr[1:0]});
        if (s == 0) return 1'b1;
        return (int'(a[11:0]) % s) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] code, input logic [31:0] a);
        int     base;
        int     s;
        longint v;
        base = int'(a[11:0]);
        s    = op_size(1'b1, code);
        v    = 0;
        for (int i = 0; i < s; i++) v += longint'(mbytes[base + i]) << (8 * i);
        if (!code[2] && s < 4 && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] code, input logic [31:0] a, input logic [31:0] wd);
        int base;
        int s;
        base = int'(a[11:0]);
        s    = op_size(1'b0, {1'b0, code});
        for (int i = 0; i < s; i++) mbytes[base + i] = wd[8*i +: 8];
    endtask

    task automatic release_bus();
        read_s  = 4'd0;
        write_s = 3'd0;
    endtask

    // Presents a request at a falling edge and counts BUSY-high cycles until it drops.
    task automatic do_op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                         input logic [31:0] wd, output int n, output logic e);
        n = 0;
        @(negedge clk);
        read_s  = rd;
        write_s = wr;
        addr_s  = a;
        wdata_s = wd;
        #1;
        e = err_s;
        while (busy_s === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic txn(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold);
        int   n;
        logic e;
        logic ee;
        ee = model_err(rd, wr, a);
        do_op(rd, wr, a, wd, n, e);
        chk({tag, "_err"}, 32'(e), 32'(ee));
        chk({tag, "_busy"}, 32'(n), ee ? 32'd0 : 32'(LAT));
        if (!ee) begin
            if (rd[3]) exp_rd = model_load(rd[2:0], a);
            else       model_store(wr[1:0], a, wd);
        end
        chk({tag, "_rdata"}, read_data_s, exp_rd);
        if (!hold) release_bus();
    endtask

    initial begin
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] a;
        int          sel;

        rst     = 1'b1;
        read_s  = 4'd0;
        write_s = 3'd0;
        addr_s  = 32'd0;
        wdata_s = 32'd0;
        exp_rd  = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rdata", read_data_s, 32'd0);
        chk("reset_busy", 32'(busy_s), 32'd0);
        chk("reset_error", 32'(err_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 64; w++) txn("init", 4'd0, 3'b110, 32'(w * 4), $urandom, 1'b0);

        // Store/load round trip and sub-word lanes.
        txn("sw_10", 4'd0, 3'b110, 32'h10, 32'hDEADBEEF, 1'b0);
        txn("lw_10", 4'b1010, 3'd0, 32'h10, 32'd0, 1'b0);
        chk("lw_10_lit", read_data_s, 32'hDEADBEEF);
        txn("sb_13", 4'd0, 3'b100, 32'h13, 32'h00000080, 1'b0);
        txn("lb_13", 4'b1000, 3'd0, 32'h13, 32'd0, 1'b0);
        chk("lb_13_lit", read_data_s, 32'hFFFFFF80);
        txn("lbu_13", 4'b1100, 3'd0, 32'h13, 32'd0, 1'b0);
        chk("lbu_13_lit", read_data_s, 32'h00000080);
        txn("lw_10b", 4'b1010, 3'd0, 32'h10, 32'd0, 1'b0);
        chk("lw_10b_lit", read_data_s, 32'h80ADBEEF);

        // Rejected requests leave everything untouched.
        txn("lh_11", 4'b1001, 3'd0, 32'h11, 32'd0, 1'b0);
        chk("lh_11_lit", read_data_s, 32'h80ADBEEF);
        txn("sw_12", 4'd0, 3'b110, 32'h12, 32'h11111111, 1'b0);
        txn("lw_10c", 4'b1010, 3'd0, 32'h10, 32'd0, 1'b0);
        chk("lw_10c_lit", read_data_s, 32'h80ADBEEF);

        // Back-to-back loads with the request held through DONE.
        txn("b2b0", 4'b1010, 3'd0, 32'h0, 32'd0, 1'b1);
        txn("b2b1", 4'b1010, 3'd0, 32'h4, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("no_double_issue", 32'(busy_s), 32'd0);

        // Reset in the middle of a store.
        txn("sw_20", 4'd0, 3'b110, 32'h20, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        write_s = 3'b110;
        addr_s  = 32'h20;
        wdata_s = 32'h00001234;
        #1;
        chk("rst_idle_busy", 32'(busy_s), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_access_busy", 32'(busy_s), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy_drop", 32'(busy_s), 32'd0);
        chk("rst_rdata", read_data_s, 32'd0);
        exp_rd = 32'd0;
        release_bus();
        @(negedge clk);
        rst = 1'b0;
        txn("lw_20", 4'b1010, 3'd0, 32'h20, 32'd0, 1'b0);
        chk("lw_20_lit", read_data_s, 32'hCAFEF00D);

        // Upper address bits wrap onto the array.
        txn("sw_1000", 4'd0, 3'b110, 32'h1000, 32'hA5A5A5A5, 1'b0);
        txn("lw_0", 4'b1010, 3'd0, 32'h0, 32'd0, 1'b0);
        chk("lw_0_lit", read_data_s, 32'hA5A5A5A5);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, 255) | ($urandom_range(0, 15) << 12);
            rd  = 4'd0;
            wr  = 3'd0;
            if (sel < 5)      rd = {1'b1, 3'($urandom_range(0, 7))};
            else if (sel < 9) wr = {1'b1, 2'($urandom_range(0, 3))};
            else begin
                rd = 4'b1010;
                wr = 3'b110;
            end
            txn("rand", rd, wr, a, $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
